// File: rtl/axi_data_fifo_sync_fwft_if.sv
// Push/pop handshake, status and control bundle of the FWFT data FIFO.
// master = producer/consumer logic, slave = the FIFO itself.
interface axi_data_fifo_sync_fwft_if #(
    parameter int WIDTH   = 144,
    parameter int CNT_WID = 7
);
    logic               data_fifo_push;
    logic [WIDTH-1:0]   data_fifo_data_in;
    logic               data_fifo_full;
    logic               data_fifo_afull;
    logic [CNT_WID-1:0] cfg_afull_thresh;
    logic               data_fifo_pop;
    logic [WIDTH-1:0]   data_fifo_data_out;
    logic               data_fifo_empty;
    logic [CNT_WID-1:0] data_fifo_word_cnt;
    logic               data_fifo_init;
    logic               data_fifo_ovf;
    logic               data_fifo_udf;

    modport master (
        output data_fifo_push, data_fifo_data_in, cfg_afull_thresh,
        output data_fifo_pop, data_fifo_init,
        input  data_fifo_full, data_fifo_afull, data_fifo_data_out,
        input  data_fifo_empty, data_fifo_word_cnt,
        input  data_fifo_ovf, data_fifo_udf
    );

    modport slave (
        input  data_fifo_push, data_fifo_data_in, cfg_afull_thresh,
        input  data_fifo_pop, data_fifo_init,
        output data_fifo_full, data_fifo_afull, data_fifo_data_out,
        output data_fifo_empty, data_fifo_word_cnt,
        output data_fifo_ovf, data_fifo_udf
    );
endinterface

// File: rtl/axi_data_fifo_sync_fwft.sv
// First-word-fall-through data FIFO over a 1-cycle-latency two-port SRAM,
// with a 2-entry prefetch (head + skid), almost-full and sticky error flags.
module axi_data_fifo_sync_fwft #(
    parameter int FIFO_WIDTH   = 144,
    parameter int FIFO_DEPTH   = 64,
    parameter int FIFO_CNT_WID = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_data_fifo_sync_fwft_if.slave      fifo,
    output logic [$clog2(FIFO_DEPTH)-1:0] sram_waddr,
    output logic                          sram_wceb,
    output logic [FIFO_WIDTH-1:0]         sram_wdata,
    output logic [$clog2(FIFO_DEPTH)-1:0] sram_raddr,
    output logic                          sram_rceb,
    input  logic [FIFO_WIDTH-1:0]         sram_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = FIFO_CNT_WID;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         word_cnt, sram_cnt;
    logic                  head_v, skid_v, inflight;
    logic                  ovf, udf;
    logic [FIFO_WIDTH-1:0] head_q, skid_q;

    logic                  live, full;
    logic                  push_acc, pop_acc, issue;
    logic [2:0]            pf_load;
    logic                  head_vn, skid_vn;
    logic [FIFO_WIDTH-1:0] head_n, skid_n;

    // Init and reset both block acceptance and read issue in their cycle.
    assign live     = rst_n && !fifo.data_fifo_init;
    assign full     = (word_cnt == FULL_CNT);
    assign push_acc = live && fifo.data_fifo_push && !full;
    assign pop_acc  = live && fifo.data_fifo_pop && head_v;

    assign pf_load = {2'b0, head_v} + {2'b0, skid_v} + {2'b0, inflight};
    assign issue   = live && (sram_cnt != '0)
                   && (pf_load < (3'd2 + {2'b0, pop_acc}));

    always_comb begin
        head_n  = head_q;
        skid_n  = skid_q;
        head_vn = head_v;
        skid_vn = skid_v;
        if (pop_acc) begin
            head_n  = skid_q;
            head_vn = skid_v;
            skid_vn = 1'b0;
        end
        if (inflight) begin
            if (!head_vn) begin
                head_n  = sram_rdata;
                head_vn = 1'b1;
            end else begin
                skid_n  = sram_rdata;
                skid_vn = 1'b1;
            end
        end
    end

    // Clearing inflight on init is what discards a read already issued.
    always_ff @(posedge clk) begin
        if (!live) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
            sram_cnt <= '0;
            head_v   <= 1'b0;
            skid_v   <= 1'b0;
            inflight <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (issue)    rd_ptr <= rd_ptr + AW'(1);
            word_cnt <= word_cnt + CW'(push_acc) - CW'(pop_acc);
            sram_cnt <= sram_cnt + CW'(push_acc) - CW'(issue);
            inflight <= issue;
            head_v   <= head_vn;
            skid_v   <= skid_vn;
            head_q   <= head_n;
            skid_q   <= skid_n;
            ovf      <= ovf | (fifo.data_fifo_push && full);
            udf      <= udf | (fifo.data_fifo_pop && !head_v);
        end
    end

    assign sram_wceb  = !push_acc;
    assign sram_waddr = wr_ptr;
    assign sram_wdata = fifo.data_fifo_data_in;
    assign sram_rceb  = !issue;
    assign sram_raddr = rd_ptr;

    assign fifo.data_fifo_full     = full;
    assign fifo.data_fifo_afull    = (word_cnt >= fifo.cfg_afull_thresh);
    assign fifo.data_fifo_empty    = !head_v;
    assign fifo.data_fifo_data_out = head_q;
    assign fifo.data_fifo_word_cnt = word_cnt;
    assign fifo.data_fifo_ovf      = ovf;
    assign fifo.data_fifo_udf      = udf;
endmodule

// File: tb/tb_axi_data_fifo_sync_fwft.sv
// Directed bench for axi_data_fifo_sync_fwft: per-cycle vector table
// plus fill/drain, streaming and flush-with-read-in-flight sequences.
module tb_axi_data_fifo_sync_fwft;
    localparam int W  = 144;
    localparam int D  = 64;
    localparam int CW = 7;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic          sram_wceb, sram_rceb;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata = '0;
    logic [W-1:0]  mem [D];

    int n_cmp = 0;
    int n_err = 0;

    axi_data_fifo_sync_fwft_if #(.WIDTH(W), .CNT_WID(CW)) bus ();

    axi_data_fifo_sync_fwft #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_CNT_WID(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo       (bus),
        .sram_waddr (sram_waddr),
        .sram_wceb  (sram_wceb),
        .sram_wdata (sram_wdata),
        .sram_raddr (sram_raddr),
        .sram_rceb  (sram_rceb),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_wceb) mem[sram_waddr] <= sram_wdata;
        if (!sram_rceb) sram_rdata <= mem[sram_raddr];
    end

    typedef struct {
        logic          push;
        logic [15:0]   din;
        logic          pop;
        logic          init;
        logic          e_empty;
        logic [CW-1:0] e_cnt;
        logic          e_full;
        logic          e_afull;
        logic          e_ovf;
        logic          e_udf;
        logic          e_rceb;
        logic          e_wceb;
        logic          c_dout;
        logic [15:0]   e_dout;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic [W-1:0] din,
                         input logic pop, input logic init);
        bus.data_fifo_push    = push;
        bus.data_fifo_data_in = din;
        bus.data_fifo_pop     = pop;
        bus.data_fifo_init    = init;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1, 16'h1,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0};
        vt[1]  = '{0, 16'h0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0};
        vt[2]  = '{0, 16'h0,  0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0};
        vt[3]  = '{0, 16'h0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 16'h1};
        vt[4]  = '{0, 16'h0,  1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 16'h1};
        vt[5]  = '{0, 16'h0,  0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0};
        vt[6]  = '{0, 16'h0,  1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0};
        vt[7]  = '{0, 16'h0,  0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 16'h0};
        vt[8]  = '{1, 16'h22, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0};
        vt[9]  = '{0, 16'h0,  0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 16'h0};
        vt[10] = '{1, 16'h33, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 16'h0};
        vt[11] = '{0, 16'h0,  0, 0, 0, 2, 0, 1, 0, 1, 0, 1, 1, 16'h22};
        vt[12] = '{0, 16'h0,  0, 1, 0, 2, 0, 1, 0, 1, 1, 1, 1, 16'h22};
        vt[13] = '{0, 16'h0,  0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0};
        vt[14] = '{0, 16'h0,  0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0};

        rst_n = 1'b0;
        bus.cfg_afull_thresh = 7'd2;
        drive(0, '0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].push, W'(vt[i].din), vt[i].pop, vt[i].init);
            #1;
            chk($sformatf("v%0d.empty", i), W'(bus.data_fifo_empty), W'(vt[i].e_empty));
            chk($sformatf("v%0d.cnt", i), W'(bus.data_fifo_word_cnt), W'(vt[i].e_cnt));
            chk($sformatf("v%0d.full", i), W'(bus.data_fifo_full), W'(vt[i].e_full));
            chk($sformatf("v%0d.afull", i), W'(bus.data_fifo_afull), W'(vt[i].e_afull));
            chk($sformatf("v%0d.ovf", i), W'(bus.data_fifo_ovf), W'(vt[i].e_ovf));
            chk($sformatf("v%0d.udf", i), W'(bus.data_fifo_udf), W'(vt[i].e_udf));
            chk($sformatf("v%0d.rceb", i), W'(sram_rceb), W'(vt[i].e_rceb));
            chk($sformatf("v%0d.wceb", i), W'(sram_wceb), W'(vt[i].e_wceb));
            if (vt[i].c_dout)
                chk($sformatf("v%0d.dout", i), bus.data_fifo_data_out, W'(vt[i].e_dout));
            next_cycle();
        end

        // Fill to full with threshold 48, overflow, then drain in order.
        bus.cfg_afull_thresh = 7'd48;
        for (int i = 0; i < 64; i++) begin
            drive(1, W'(i), 0, 0);
            #1;
            if (i == 47) chk("fill.afull47", W'(bus.data_fifo_afull), W'(0));
            if (i == 48) chk("fill.afull48", W'(bus.data_fifo_afull), W'(1));
            next_cycle();
        end
        drive(1, W'(64), 0, 0);
        #1;
        chk("full.flag", W'(bus.data_fifo_full), W'(1));
        chk("full.cnt", W'(bus.data_fifo_word_cnt), W'(64));
        chk("full.wceb", W'(sram_wceb), W'(1));
        next_cycle();
        drive(1, W'(99), 1, 0);
        #1;
        chk("ovf.flag", W'(bus.data_fifo_ovf), W'(1));
        chk("ovf.cnt", W'(bus.data_fifo_word_cnt), W'(64));
        chk("ovf.head", bus.data_fifo_data_out, W'(0));
        next_cycle();
        for (int k = 1; k < 64; k++) begin
            drive(0, '0, 1, 0);
            #1;
            chk($sformatf("drain%0d.empty", k), W'(bus.data_fifo_empty), W'(0));
            chk($sformatf("drain%0d.dout", k), bus.data_fifo_data_out, W'(k));
            chk($sformatf("drain%0d.cnt", k), W'(bus.data_fifo_word_cnt), W'(64 - k));
            chk($sformatf("drain%0d.afull", k), W'(bus.data_fifo_afull),
                W'((64 - k) >= 48));
            next_cycle();
        end
        drive(0, '0, 0, 0);
        #1;
        chk("drained.empty", W'(bus.data_fifo_empty), W'(1));
        chk("drained.cnt", W'(bus.data_fifo_word_cnt), W'(0));
        chk("drained.udf", W'(bus.data_fifo_udf), W'(0));

        // Streaming: push every cycle, pop from cycle 3, pointers wrap 3x.
        for (int c = 0; c < 203; c++) begin
            drive(c < 200, W'(16'h1000 + c), c >= 3, 0);
            #1;
            if (c >= 3) begin
                chk($sformatf("stream%0d.empty", c), W'(bus.data_fifo_empty), W'(0));
                chk($sformatf("stream%0d.dout", c), bus.data_fifo_data_out,
                    W'(16'h1000 + c - 3));
            end
            if (c >= 3 && c <= 200)
                chk($sformatf("stream%0d.cnt", c), W'(bus.data_fifo_word_cnt), W'(3));
            next_cycle();
        end
        drive(0, '0, 0, 0);
        #1;
        chk("stream.end_empty", W'(bus.data_fifo_empty), W'(1));
        chk("stream.end_cnt", W'(bus.data_fifo_word_cnt), W'(0));

        // Flush while a read is in flight with 10 words held.
        for (int i = 0; i < 11; i++) begin
            drive(1, W'(16'h200 + i), 0, 0);
            next_cycle();
        end
        drive(0, '0, 0, 0);
        repeat (3) next_cycle();
        drive(0, '0, 1, 0);
        #1;
        chk("flush.pre_head", bus.data_fifo_data_out, W'(16'h200));
        chk("flush.pre_rceb", W'(sram_rceb), W'(0));
        next_cycle();
        drive(0, '0, 0, 1);
        #1;
        chk("flush.pre_cnt", W'(bus.data_fifo_word_cnt), W'(10));
        chk("flush.pre_ovf", W'(bus.data_fifo_ovf), W'(1));
        next_cycle();
        drive(1, W'(16'hA), 0, 0);
        #1;
        chk("flush.cnt", W'(bus.data_fifo_word_cnt), W'(0));
        chk("flush.empty", W'(bus.data_fifo_empty), W'(1));
        chk("flush.ovf", W'(bus.data_fifo_ovf), W'(0));
        chk("flush.udf", W'(bus.data_fifo_udf), W'(0));
        chk("flush.full", W'(bus.data_fifo_full), W'(0));
        chk("flush.dout", bus.data_fifo_data_out, W'(0));
        chk("flush.wceb", W'(sram_wceb), W'(0));
        next_cycle();
        drive(0, '0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            #1;
            chk($sformatf("flush.stale%0d", j), W'(bus.data_fifo_empty), W'(1));
            next_cycle();
        end
        #1;
        chk("flush.new_empty", W'(bus.data_fifo_empty), W'(0));
        chk("flush.new_head", bus.data_fifo_data_out, W'(16'hA));
        chk("flush.new_cnt", W'(bus.data_fifo_word_cnt), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_data_fifo_sync_fwft.md
# axi_data_fifo_sync_fwft

Parametrised first-word-fall-through data FIFO for the iDMA read-data path, backed by an external two-port SRAM with 1-cycle read latency. It supersedes the fixed 64x144 data FIFO and adds four things:

- a 2-entry prefetch stage, so the head word sits on the output with no pop-to-data delay;
- a programmable almost-full threshold;
- sticky overflow and underflow flags;
- synchronous flush that also discards in-flight SRAM reads.

It sits between the AXI R-channel unpacker (push side) and the iDMA write-out logic (pop side).

## Interface
Parameters:
- FIFO_WIDTH, 144: data width in bits (128 data + 16 sideband).
- FIFO_DEPTH, 64: total capacity in words. Must be a power of two, ≥4. This is also the SRAM depth.
- FIFO_CNT_WID, 7: equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  **synchronous, active-low reset**.
- data_fifo_push  in  1  write request.
- data_fifo_data_in  in  FIFO_WIDTH  write data.
- data_fifo_full  out  1  no free entries.
- data_fifo_afull  out  1  data_fifo_word_cnt ≥ cfg_afull_thresh.
- cfg_afull_thresh  in  FIFO_CNT_WID  almost-full threshold; quasi-static.
- data_fifo_pop  in  1  read request; consumes the head word.
- data_fifo_data_out  out  FIFO_WIDTH  head word; valid while !data_fifo_empty.
- data_fifo_empty  out  1  no word at the head.
- data_fifo_word_cnt  out  FIFO_CNT_WID  total words held: SRAM + in-flight read + prefetch.
- data_fifo_init  in  1  synchronous flush.
- data_fifo_ovf  out  1  sticky: push attempted while full.
- data_fifo_udf  out  1  sticky: pop attempted while empty.
- sram_waddr  out  log2(FIFO_DEPTH)  SRAM write address.
- sram_wceb  out  1  SRAM write enable, active-low.
- sram_wdata  out  FIFO_WIDTH  SRAM write data.
- sram_raddr  out  log2(FIFO_DEPTH)  SRAM read address.
- sram_rceb  out  1  SRAM read enable, active-low.
- sram_rdata  in  FIFO_WIDTH  SRAM read data; valid the cycle after sram_rceb=0.

## Operation
Acceptance:
- Push is accepted iff data_fifo_push && !data_fifo_full.
- Pop is accepted iff data_fifo_pop && !data_fifo_empty.
- A rejected push is dropped and sets data_fifo_ovf. A rejected pop sets data_fifo_udf.
- Both sticky flags clear only on reset or init.

Write path:
- On an accepted push: sram_wceb=0, sram_waddr=wr_ptr, sram_wdata=data_fifo_data_in, combinationally in the same cycle.
- wr_ptr increments and wraps modulo FIFO_DEPTH.

Read/prefetch path:
- Prefetch is 2 entries (head + skid), FIFO-ordered. data_fifo_data_out is the head entry.
- A read is issued (sram_rceb=0, sram_raddr=rd_ptr) when SRAM occupancy > 0 and (prefetch occupancy + in-flight − pop accepted this cycle) < 2.
- At most 1 read is in flight. rd_ptr increments on issue and wraps.
- A returning sram_rdata is written to the head if the stage will be empty, otherwise to the skid.
- A pop shifts skid→head.
- A word written this cycle is not readable from SRAM until the next cycle. There is no write-to-read bypass.

Counters and flags:
- word_cnt += accepted push, −= accepted pop.
- data_fifo_full = (word_cnt == FIFO_DEPTH). This guarantees the SRAM can never overwrite unread data.
- data_fifo_empty = head entry invalid. It is registered state, not derived from word_cnt.
- data_fifo_afull = (word_cnt ≥ cfg_afull_thresh), combinational from the registered count. Threshold 0 gives afull=1.

Priority and simultaneous events:
- rst_n=0 overrides init; init overrides push/pop.
- Init clears pointers, counts, prefetch and sticky flags, and marks any in-flight read as discarded: its rdata is ignored.
- Push and pop in the same cycle are each evaluated against the flags at the start of the cycle.
- At full: the pop is accepted, the push is rejected (ovf=1), and word_cnt drops by 1.
- At empty: the push is accepted, the pop is rejected (udf=1), and word_cnt becomes 1.

Reset/init values:
- data_fifo_empty=1, data_fifo_full=0, data_fifo_word_cnt=0.
- data_fifo_ovf=0, data_fifo_udf=0, data_fifo_data_out=0.
- sram_rceb=1, sram_wceb=1.
- data_fifo_afull = (0 ≥ cfg_afull_thresh).

## Timing
- First-word latency from a push in cycle 0 into an empty FIFO:
  - cycle 1: sram_rceb=0;
  - cycle 2: sram_rdata valid, captured at the end of the cycle;
  - cycle 3: data_fifo_empty=0 and data_out valid.
- data_fifo_full, data_fifo_word_cnt and the sticky flags update on the edge after the event.
- Sustained throughput is 1 push and 1 pop per cycle with no bubbles, once the prefetch is primed.
- Pop-to-next-head: 0 cycles. After an accepted pop, the next word is on data_out in the following cycle if the skid was valid.
- Init in cycle N: all outputs take their reset values from cycle N+1. A push in cycle N+1 is accepted normally.

## Test plan
- Reset, then push 0x1 in cycle 0 → sram_rceb=0 in cycle 1; data_fifo_empty=0 and data_out=0x1 in cycle 3; word_cnt=1 from cycle 1.
- Push 64 words (values 0..63) back-to-back, then pop continuously → full=1 after the 64th push; a 65th push sets ovf=1 and word_cnt stays 64; pops return 0..63 in order with no bubbles after the first.
- Continuous push + pop for 200 cycles with DEPTH=64 → pointers wrap 3 times; data in = data out in order; word_cnt stable.
- cfg_afull_thresh=48: push 47 words → afull=0; push the 48th → afull=1; pop 1 → afull=0.
- Pop on empty, and push+pop at full → udf=1 / ovf=1 respectively; full-case word_cnt 64→63.
- Init asserted while a read is in flight with 10 words stored → next cycle word_cnt=0, empty=1, flags=0; the stale rdata never appears; a following push of 0xA emerges as the head.
